// File: rtl/lane_scalar_xchg_pkg.sv
// Shared types for the lane <-> scalar-unit exchange block.
// Sizes here describe the default 16-lane / 32-bit configuration.
package lane_scalar_xchg_pkg;
  localparam int XCHG_NUM_LANES = 16;
  localparam int XCHG_WIDTH     = 32;

  typedef logic [XCHG_WIDTH-1:0]              data_t;
  typedef logic [$clog2(XCHG_NUM_LANES)-1:0]  lane_id_t;

  typedef struct packed {
    lane_id_t lane;
    data_t    data;
  } xchg_entry_t;

  typedef logic [1:0] bc_state_t;
  localparam bc_state_t BC_IDLE  = 2'd0;
  localparam bc_state_t BC_HOLD  = 2'd1;
  localparam bc_state_t BC_ISSUE = 2'd2;
endpackage

// File: rtl/lane_scalar_xchg_arbiter.sv
// One-grant-per-cycle arbiter over the lane pending vector.
// LANE_SCALAR_RR_EN selects round-robin; otherwise lowest lane index wins.
module lane_scalar_xchg_arbiter #(
  parameter int NUM_LANES = 16
) (
`ifdef LANE_SCALAR_RR_EN
  input  logic                         clock,
  input  logic                         reset,
`endif
  input  logic [NUM_LANES-1:0]         i_pend,
  input  logic                         i_en,
  output logic [NUM_LANES-1:0]         o_gnt,
  output logic [$clog2(NUM_LANES)-1:0] o_idx,
  output logic                         o_vld
);
  localparam int LW = $clog2(NUM_LANES);

  logic [LW-1:0] w_base;
  logic [LW-1:0] w_j;
  logic          w_hit;

`ifdef LANE_SCALAR_RR_EN
  logic [LW-1:0] r_ptr;

  // Power-of-two lane count makes the +1 wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_ptr <= '0;
    else if (o_vld) r_ptr <= o_idx + 1'b1;
  end

  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  // Scan from the base downwards so the lane nearest the base wins last.
  always_comb begin
    w_j   = '0;
    w_hit = 1'b0;
    o_idx = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      w_j = w_base + LW'(k);
      if (i_pend[w_j]) begin
        o_idx = w_j;
        w_hit = 1'b1;
      end
    end
  end

  assign o_vld = i_en & w_hit;
  assign o_gnt = o_vld ? (NUM_LANES'(1) << o_idx) : '0;
endmodule

// File: rtl/lane_scalar_xchg.sv
// Lane aux-register <-> scalar unit exchange: upstream capture/arbitrate/FIFO,
// downstream broadcast FSM. LANE_SCALAR_RR_EN enables round-robin arbitration.
module lane_scalar_xchg
  import lane_scalar_xchg_pkg::*;
#(
  parameter int NUM_LANES = XCHG_NUM_LANES,
  parameter int DEPTH     = 4,
  parameter int WIDTH     = XCHG_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         I_Stall,
  input  logic [NUM_LANES-1:0]         I_Lane_We,
  input  logic [NUM_LANES*WIDTH-1:0]   I_Lane_Data,
  output logic                         O_Up_Valid,
  output logic [WIDTH-1:0]             O_Up_Data,
  output logic [$clog2(NUM_LANES)-1:0] O_Up_Lane,
  input  logic                         I_Up_Ready,
  input  logic                         I_Bc_Valid,
  input  logic [WIDTH-1:0]             I_Bc_Data,
  output logic                         O_Bc_Busy,
  output logic                         O_SWe,
  output logic [WIDTH-1:0]             O_Scalar_Data,
  output logic                         O_Overrun
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [LW-1:0]    lane;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [NUM_LANES-1:0] r_pend;
  logic [WIDTH-1:0]     r_cap [NUM_LANES];
  logic                 r_ovr;
  entry_t               r_mem [DEPTH];
  logic [AW:0]          r_wr, r_rd;
  bc_state_t            r_state;
  logic [WIDTH-1:0]     r_hold, r_scal;

  logic                 w_empty, w_full, w_pop, w_arb_en;
  logic [NUM_LANES-1:0] w_gnt;
  logic [LW-1:0]        w_gidx;
  logic                 w_gvld;
  entry_t               w_head;

  assign w_empty  = (r_wr == r_rd);
  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop    = !w_empty && I_Up_Ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a grant.
  assign w_arb_en = !w_full || w_pop;

  lane_scalar_xchg_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
`ifdef LANE_SCALAR_RR_EN
    .clock (clock),
    .reset (reset),
`endif
    .i_pend(r_pend),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_vld (w_gvld)
  );

  // A fresh strobe on a granted lane re-arms pending without counting as overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_gnt) | I_Lane_We;
      if (|(I_Lane_We & r_pend & ~w_gnt)) r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (I_Lane_We[i]) r_cap[i] <= I_Lane_Data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_gvld) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_gvld) r_mem[r_wr[AW-1:0]] <= '{lane: w_gidx, data: r_cap[w_gidx]};
  end

  // Head is masked while empty so stale storage never leaks after a reset.
  assign w_head     = r_mem[r_rd[AW-1:0]];
  assign O_Up_Valid = !w_empty;
  assign O_Up_Data  = w_empty ? '0 : w_head.data;
  assign O_Up_Lane  = w_empty ? '0 : w_head.lane;
  assign O_Overrun  = r_ovr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= BC_IDLE;
      r_scal  <= '0;
    end else begin
      case (r_state)
        BC_IDLE: begin
          if (I_Bc_Valid) begin
            if (I_Stall) r_state <= BC_HOLD;
            else begin
              r_state <= BC_ISSUE;
              r_scal  <= I_Bc_Data;
            end
          end
        end
        BC_HOLD: begin
          if (!I_Stall) begin
            r_state <= BC_ISSUE;
            r_scal  <= r_hold;
          end
        end
        BC_ISSUE: r_state <= BC_IDLE;
        default:  r_state <= BC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == BC_IDLE && I_Bc_Valid) r_hold <= I_Bc_Data;
  end

  assign O_Bc_Busy     = (r_state != BC_IDLE);
  assign O_SWe         = (r_state == BC_ISSUE);
  assign O_Scalar_Data = r_scal;

  // The scalar unit must not request a broadcast while one is held.
  always @(posedge clock) begin
    if (reset) assert (!(O_Bc_Busy && I_Bc_Valid))
      else $error("broadcast requested while busy");
  end
endmodule

// File: tb/tb_lane_scalar_xchg.sv
// Scoreboard bench for lane_scalar_xchg: queue-based reference model plus
// directed scenarios and randomized traffic.
module tb_lane_scalar_xchg;
  localparam int NL = 16;
  localparam int W  = 32;
  localparam int DP = 4;

  typedef struct packed {
    logic [3:0]  lane;
    logic [31:0] data;
  } ent_t;

  logic            clock, reset, I_Stall, I_Up_Ready, I_Bc_Valid;
  logic [NL-1:0]   I_Lane_We;
  logic [NL*W-1:0] I_Lane_Data;
  logic [W-1:0]    I_Bc_Data;
  logic            O_Up_Valid, O_Bc_Busy, O_SWe, O_Overrun;
  logic [W-1:0]    O_Up_Data, O_Scalar_Data;
  logic [3:0]      O_Up_Lane;

  lane_scalar_xchg #(.NUM_LANES(NL), .DEPTH(DP), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .I_Stall(I_Stall),
    .I_Lane_We(I_Lane_We), .I_Lane_Data(I_Lane_Data),
    .O_Up_Valid(O_Up_Valid), .O_Up_Data(O_Up_Data), .O_Up_Lane(O_Up_Lane),
    .I_Up_Ready(I_Up_Ready), .I_Bc_Valid(I_Bc_Valid), .I_Bc_Data(I_Bc_Data),
    .O_Bc_Busy(O_Bc_Busy), .O_SWe(O_SWe), .O_Scalar_Data(O_Scalar_Data),
    .O_Overrun(O_Overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lane values wait in a pending set, move one per cycle into a
  // bounded ordered queue, and leave it on each accepted handshake.
  logic        m_pend [NL];
  logic [31:0] m_cap  [NL];
  logic        m_old  [NL];
  int          m_cnt, m_ptr, g, idx;
  bit          m_ovr, m_held, m_issue, pop;
  logic [31:0] m_hval, m_scal;
  ent_t        exp_q[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NL; i++) m_pend[i] = 1'b0;
      m_cnt = 0; m_ptr = 0; m_ovr = 0;
      m_held = 0; m_issue = 0; m_scal = '0;
      exp_q.delete();
    end else begin
      pop = (m_cnt > 0) && I_Up_Ready;
      g = -1;
      if (m_cnt < DP || pop)
        for (int k = 0; k < NL; k++) begin
          idx = (m_ptr + k) % NL;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      for (int i = 0; i < NL; i++) m_old[i] = m_pend[i];
      if (g >= 0) begin
        exp_q.push_back('{lane: 4'(g), data: m_cap[g]});
        m_pend[g] = 1'b0;
        m_cnt++;
`ifdef LANE_SCALAR_RR_EN
        m_ptr = (g + 1) % NL;
`endif
      end
      for (int i = 0; i < NL; i++)
        if (I_Lane_We[i]) begin
          if (m_old[i] && i != g) m_ovr = 1;
          m_cap[i]  = I_Lane_Data[i*W +: W];
          m_pend[i] = 1'b1;
        end
      if (pop) m_cnt--;
      if (m_issue) m_issue = 0;
      else if (m_held) begin
        if (!I_Stall) begin m_held = 0; m_issue = 1; m_scal = m_hval; end
      end else if (I_Bc_Valid) begin
        if (I_Stall) begin m_held = 1; m_hval = I_Bc_Data; end
        else begin m_issue = 1; m_scal = I_Bc_Data; end
      end
    end
  end

  // Monitor: mid-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    if (reset) begin
      chk("up_valid", 64'(O_Up_Valid), 64'(m_cnt > 0));
      if (O_Up_Valid && exp_q.size() > 0) begin
        chk("up_lane", 64'(O_Up_Lane), 64'(exp_q[0].lane));
        chk("up_data", 64'(O_Up_Data), 64'(exp_q[0].data));
        if (I_Up_Ready) void'(exp_q.pop_front());
      end
      chk("overrun", 64'(O_Overrun), 64'(m_ovr));
      chk("bc_busy", 64'(O_Bc_Busy), 64'(m_held || m_issue));
      chk("swe", 64'(O_SWe), 64'(m_issue));
      chk("scalar_data", 64'(O_Scalar_Data), 64'(m_scal));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input int lane, input logic [31:0] val);
    I_Lane_We[lane] = 1'b1;
    I_Lane_Data[lane*W +: W] = val;
  endtask

  initial begin
    reset = 1'b0; I_Stall = 0; I_Up_Ready = 0; I_Bc_Valid = 0; I_Bc_Data = '0;
    I_Lane_We = '0; I_Lane_Data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 64'(O_Up_Valid), 64'(0));
    chk("rst_data", 64'(O_Up_Data), 64'(0));
    chk("rst_ovr", 64'(O_Overrun), 64'(0));
    chk("rst_swe", 64'(O_SWe), 64'(0));
    chk("rst_busy", 64'(O_Bc_Busy), 64'(0));
    chk("rst_scalar", 64'(O_Scalar_Data), 64'(0));
    reset = 1'b1;
    step();

    // Single strobe latency.
    strobe(3, 32'hDEADBEEF);
    step(); I_Lane_We = '0;
    chk("lat_t1_valid", 64'(O_Up_Valid), 64'(0));
    step();
    chk("lat_t2_valid", 64'(O_Up_Valid), 64'(1));
    chk("lat_t2_lane", 64'(O_Up_Lane), 64'(3));
    chk("lat_t2_data", 64'(O_Up_Data), 64'hDEADBEEF);
    I_Up_Ready = 1; step(); I_Up_Ready = 0;
    chk("lat_popped", 64'(O_Up_Valid), 64'(0));

    // Simultaneous strobes with the consumer always ready.
    I_Up_Ready = 1;
    strobe(1, 32'h11); strobe(5, 32'h55); strobe(9, 32'h99);
    step(); I_Lane_We = '0;
    repeat (8) step();

    // FIFO full: six lanes with the consumer stalled, then released.
    I_Up_Ready = 0;
    for (int i = 0; i < 6; i++) strobe(2 * i, 32'h100 + i);
    step(); I_Lane_We = '0;
    repeat (8) step();
    chk("full_valid", 64'(O_Up_Valid), 64'(1));
    I_Up_Ready = 1; repeat (10) step();
    chk("full_no_ovr", 64'(O_Overrun), 64'(0));

    // Overrun on lane 2 while the FIFO is full.
    I_Up_Ready = 0;
    strobe(0, 32'hA0); strobe(1, 32'hA1); strobe(3, 32'hA3); strobe(4, 32'hA4);
    step(); I_Lane_We = '0;
    repeat (6) step();
    strobe(2, 32'h1); step();
    strobe(2, 32'h2); step(); I_Lane_We = '0;
    step();
    chk("ovr_set", 64'(O_Overrun), 64'(1));
    I_Up_Ready = 1; repeat (12) step();
    chk("ovr_sticky", 64'(O_Overrun), 64'(1));

    // Broadcast held by a three-cycle stall.
    I_Stall = 1; I_Bc_Valid = 1; I_Bc_Data = 32'hA5A5;
    step(); I_Bc_Valid = 0;
    repeat (2) begin
      chk("bc_hold_busy", 64'(O_Bc_Busy), 64'(1));
      chk("bc_hold_swe", 64'(O_SWe), 64'(0));
      step();
    end
    I_Stall = 0; step();
    chk("bc_issue_swe", 64'(O_SWe), 64'(1));
    chk("bc_issue_data", 64'(O_Scalar_Data), 64'hA5A5);
    step();
    chk("bc_done_swe", 64'(O_SWe), 64'(0));
    chk("bc_keep_data", 64'(O_Scalar_Data), 64'hA5A5);

    // Asynchronous reset with queued entries and a held broadcast.
    I_Up_Ready = 0;
    strobe(7, 32'h77); strobe(11, 32'hBB); strobe(12, 32'hCC);
    step(); I_Lane_We = '0;
    repeat (4) step();
    I_Stall = 1; I_Bc_Valid = 1; I_Bc_Data = 32'h1234;
    step(); I_Bc_Valid = 0;
    step();
    reset = 1'b0;
    #2;
    chk("arst_valid", 64'(O_Up_Valid), 64'(0));
    chk("arst_lane", 64'(O_Up_Lane), 64'(0));
    chk("arst_data", 64'(O_Up_Data), 64'(0));
    chk("arst_busy", 64'(O_Bc_Busy), 64'(0));
    chk("arst_ovr", 64'(O_Overrun), 64'(0));
    chk("arst_scalar", 64'(O_Scalar_Data), 64'(0));
    repeat (2) step();
    reset = 1'b1; I_Stall = 0; I_Up_Ready = 1;
    repeat (5) step();
    chk("arst_no_stale", 64'(O_Up_Valid), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      I_Lane_We = '0;
      for (int i = 0; i < NL; i++)
        if ($urandom_range(7) == 0) strobe(i, $urandom);
      I_Up_Ready = ($urandom_range(2) != 0);
      I_Stall    = ($urandom_range(3) == 0);
      I_Bc_Valid = !O_Bc_Busy && ($urandom_range(4) == 0);
      I_Bc_Data  = $urandom;
      step();
    end

    I_Lane_We = '0; I_Bc_Valid = 0; I_Stall = 0; I_Up_Ready = 1;
    repeat (40) step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
